phys_sweep_integrator: RTL and testbench
========================================

// Module: phys_sweep_integrator
// PURPOSE
// - Sequential physics step engine. On each start pulse it sweeps NUM_OBJ dynamic-state words in an
//   external object RAM: read, integrate position/velocity over a latched time step with gravity, write back.
// - Sits between the frame/physics scheduler (start/done) and the object dynamic-state BRAM.
// - Replaces the single-object combinational pos/vel update.
// PARAMETERS
// - SF        16  signed fixed-point width of each pos/vel field
// - SF_DEC     4  fractional bits of pos/vel fields
// - DF_DEC    12  fractional bits of time_step
// - NUM_OBJ    8  number of object slots swept per step, >=1
// - GRAVITY   16  added to vel_y per unit time, in SF LSBs; +y is down
// - FLOOR_Y  2**(SF-1)-1  floor position, used only with PHYS_FLOOR_BOUNCE_EN
// PORTS
// - sys_clk        in   1              system clock
// - sys_rst        in   1              asynchronous, active-high reset
// - start          in   1              one-cycle pulse; begins a sweep (accepted only when !busy)
// - time_step      in   DF_DEC+2       signed dt; latched on an accepted start
// - obj_active     in   NUM_OBJ        per-slot enable; latched on an accepted start
// - busy           out  1              high from accepted start until done
// - done           out  1              one-cycle pulse after the last slot is handled
// - rd_en          out  1              RAM read strobe
// - rd_addr        out  $clog2(NUM_OBJ) RAM read address
// - rd_data        in   4*SF           {pos_x,pos_y,vel_x,vel_y}; valid 1 cycle after rd_en
// - wr_en          out  1              RAM write strobe
// - wr_addr        out  $clog2(NUM_OBJ) RAM write address
// - wr_data        out  4*SF           updated {pos_x,pos_y,vel_x,vel_y}
// BEHAVIOUR
// - Reset: state IDLE; busy, done, rd_en, wr_en = 0; addresses, wr_data, index = 0.
// - FSM states: IDLE -> FETCH -> CALC -> WRITE -> (FETCH | FIN) -> IDLE.
// - IDLE: on start, latch time_step and obj_active, set idx = 0, go to FETCH.
//   A start pulse while busy is ignored.
// - FETCH:
//   - obj_active[idx] = 0: skip the slot; no read, no write. Go to FIN if idx is the last slot,
//     otherwise idx++ and stay in FETCH.
//   - obj_active[idx] = 1: rd_en = 1, rd_addr = idx, go to CALC.
// - CALC: rd_data is valid. Compute and register the results, go to WRITE.
// - WRITE: wr_en = 1, wr_addr = idx, wr_data = results. Go to FIN if idx is the last slot,
//   otherwise idx++ and go to FETCH.
// - FIN: done = 1 for one cycle, busy drops in the same cycle, then IDLE.
// - Timing: with k active slots, start to done is 3k + (NUM_OBJ-k) + 1 cycles.
//   rd_en and wr_en are never both high in the same cycle.
// - Arithmetic, all signed, on intermediates of at least 2*SF+DF_DEC bits:
//   - d = (vel * dt) >>> DF_DEC
//   - pos' = clamp(pos + d, -2**(SF-1), 2**(SF-1)-1)
//   - vel_y' = clamp(vel_y + ((dt*GRAVITY) >>> DF_DEC), same range)
//   - vel_x' = vel_x
// - Negative dt is legal; it integrates backwards.
// - dt = 0 writes every active slot back unchanged.
// - Reset mid-sweep: return to IDLE immediately. The word being written may be incomplete;
//   no later slots are touched and done does not pulse.
// CONFIGURATION
// - PHYS_FLOOR_BOUNCE_EN defined: if pos_y + d_y > FLOOR_Y, then pos_y' = FLOOR_Y and
//   vel_y' = -(vel_y' >>> 1) (lossy bounce). Otherwise pos/vel follow the unclamped-by-floor rule.
// - PHYS_FLOOR_BOUNCE_EN undefined: no floor; only saturation clamping applies.
//   FLOOR_Y is unused.
// STRUCTURE
// - phys_pkg holds: SF, SF_DEC, DF_DEC widths; the obj_dyn_t packed struct {pos_x,pos_y,vel_x,vel_y};
//   the state enum; the sat_add function.
// - Sub-module phys_step_alu: registered combinational datapath, obj_dyn_t + dt -> obj_dyn_t.
//   Contains the floor logic under the macro.
// - The FSM and index counter stay in phys_sweep_integrator.
// TESTING
// 1. NUM_OBJ=4, all active, dt=1.0 (4096), slot0 pos=(0,0) vel=(16,0), GRAVITY=16
//    -> slot0 written pos=(16,0), vel=(16,16); done at cycle 13.
// 2. obj_active=4'b0101 -> writes only to addresses 0 and 2; done after 3*2+2+1 = 9 cycles;
//    slots 1 and 3 unchanged.
// 3. pos_x = 32760, vel_x = 100, dt = 1.0 -> pos_x saturates to 32767; pos_x = -32760 with
//    vel_x = -100 -> -32768.
// 4. Second start pulse while busy -> ignored; exactly one done; the latched dt is unchanged.
// 5. Assert sys_rst during slot 2 CALC -> busy = 0 next edge; no writes to slots 3..N; no done pulse.
// 6. With PHYS_FLOOR_BOUNCE_EN, FLOOR_Y = 1000, pos_y = 990, vel_y = 400, dt = 1.0
//    -> pos_y = 1000, vel_y = -208 (vel_y' = 416).

Source files
------------

// File: rtl/phys_pkg.sv
`default_nettype none
// ============================================================================
// Module      : phys_pkg
// Description : Shared widths, object dynamic-state record, sweep FSM states
//               and the saturating add used by the physics step datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package phys_pkg;

    localparam int SF     = 16;
    localparam int SF_DEC = 4;
    localparam int DF_DEC = 12;
    localparam int WIDE   = 2 * SF + DF_DEC + 4;

    typedef struct packed {
        logic signed [SF-1:0] pos_x;
        logic signed [SF-1:0] pos_y;
        logic signed [SF-1:0] vel_x;
        logic signed [SF-1:0] vel_y;
    } obj_dyn_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_CALC  = 3'd2,
        ST_WRITE = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    localparam logic signed [WIDE-1:0] c_SMAX = WIDE'(2**(SF-1) - 1);
    localparam logic signed [WIDE-1:0] c_SMIN = -c_SMAX - WIDE'(1);

    function automatic logic signed [WIDE-1:0] sext(input logic signed [SF-1:0] a);
        return {{(WIDE-SF){a[SF-1]}}, a};
    endfunction

    // Add a wide delta to a field and saturate to the field's signed range.
    function automatic logic signed [SF-1:0] sat_add(input logic signed [SF-1:0]   a,
                                                     input logic signed [WIDE-1:0] b);
        logic signed [WIDE-1:0] s;
        s = sext(a) + b;
        if (s > c_SMAX)
            return {1'b0, {(SF-1){1'b1}}};
        else if (s < c_SMIN)
            return {1'b1, {(SF-1){1'b0}}};
        else
            return s[SF-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/phys_step_alu.sv
`default_nettype none
// ============================================================================
// Module      : phys_step_alu
// Description : Registered pos/vel integrator for one object over one dt.
//               Floor bounce is built only with PHYS_FLOOR_BOUNCE_EN defined.
// Revision    : 1.0 - initial release
// ============================================================================
module phys_step_alu
    import phys_pkg::*;
#(
    parameter int GRAVITY = 16,
    parameter int FLOOR_Y = 2**(SF-1) - 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_load,
    input  obj_dyn_t                 i_obj,
    input  logic signed [DF_DEC+1:0] i_dt,
    output obj_dyn_t                 o_obj
);

    localparam logic signed [WIDE-1:0] c_GRAV = WIDE'(GRAVITY);

    logic signed [WIDE-1:0] w_dt;
    logic signed [WIDE-1:0] w_dx;
    logic signed [WIDE-1:0] w_dy;
    logic signed [WIDE-1:0] w_dv;
    obj_dyn_t               w_next;
    obj_dyn_t               r_obj;

    assign w_dt = {{(WIDE-DF_DEC-2){i_dt[DF_DEC+1]}}, i_dt};
    assign w_dx = (sext(i_obj.vel_x) * w_dt) >>> DF_DEC;
    assign w_dy = (sext(i_obj.vel_y) * w_dt) >>> DF_DEC;
    assign w_dv = (w_dt * c_GRAV) >>> DF_DEC;

`ifdef PHYS_FLOOR_BOUNCE_EN
    localparam logic signed [WIDE-1:0] c_FLOOR = WIDE'(FLOOR_Y);
    logic signed [WIDE-1:0] w_py_sum;
    assign w_py_sum = sext(i_obj.pos_y) + w_dy;
`endif

    always_comb begin
        w_next.pos_x = sat_add(i_obj.pos_x, w_dx);
        w_next.pos_y = sat_add(i_obj.pos_y, w_dy);
        w_next.vel_x = i_obj.vel_x;
        w_next.vel_y = sat_add(i_obj.vel_y, w_dv);
`ifdef PHYS_FLOOR_BOUNCE_EN
        // Crossing the floor pins the object to it and reflects half the speed.
        if (w_py_sum > c_FLOOR) begin
            w_next.pos_y = SF'(FLOOR_Y);
            w_next.vel_y = -(w_next.vel_y >>> 1);
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_obj <= '0;
        else if (i_load)
            r_obj <= w_next;
    end

    assign o_obj = r_obj;

endmodule
`default_nettype wire

// File: rtl/phys_sweep_integrator.sv
`default_nettype none
// ============================================================================
// Module      : phys_sweep_integrator
// Description : Sweeps NUM_OBJ object slots in external RAM per start pulse,
//               integrating each active slot. Option: PHYS_FLOOR_BOUNCE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module phys_sweep_integrator
    import phys_pkg::*;
#(
    parameter  int NUM_OBJ = 8,
    parameter  int GRAVITY = 16,
    parameter  int FLOOR_Y = 2**(SF-1) - 1,
    localparam int c_AW    = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     start,
    input  logic signed [DF_DEC+1:0] time_step,
    input  logic [NUM_OBJ-1:0]       obj_active,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_en,
    output logic [c_AW-1:0]          rd_addr,
    input  logic [4*SF-1:0]          rd_data,
    output logic                     wr_en,
    output logic [c_AW-1:0]          wr_addr,
    output logic [4*SF-1:0]          wr_data
);

    state_t                   r_state;
    state_t                   w_next;
    logic [c_AW-1:0]          r_idx;
    logic signed [DF_DEC+1:0] r_dt;
    logic [NUM_OBJ-1:0]       r_active;
    logic                     w_last;
    logic                     w_idx_inc;
    logic                     w_load;
    obj_dyn_t                 w_rd_obj;
    obj_dyn_t                 w_alu_obj;

    assign w_last   = (r_idx == c_AW'(NUM_OBJ - 1));
    assign w_rd_obj = obj_dyn_t'(rd_data);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_dt     <= '0;
            r_active <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && start) begin
                r_idx    <= '0;
                r_dt     <= time_step;
                r_active <= obj_active;
            end else if (w_idx_inc) begin
                r_idx <= r_idx + c_AW'(1);
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_idx_inc = 1'b0;
        w_load    = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start)
                    w_next = ST_FETCH;
            end
            ST_FETCH: begin
                // Inactive slots cost one cycle and never touch the RAM.
                if (r_active[r_idx]) begin
                    rd_en  = 1'b1;
                    w_next = ST_CALC;
                end else if (w_last) begin
                    w_next = ST_FIN;
                end else begin
                    w_idx_inc = 1'b1;
                end
            end
            ST_CALC: begin
                w_load = 1'b1;
                w_next = ST_WRITE;
            end
            ST_WRITE: begin
                wr_en = 1'b1;
                if (w_last) begin
                    w_next = ST_FIN;
                end else begin
                    w_idx_inc = 1'b1;
                    w_next    = ST_FETCH;
                end
            end
            ST_FIN: begin
                busy   = 1'b0;
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                busy   = 1'b0;
                w_next = ST_IDLE;
            end
        endcase
    end

    phys_step_alu #(
        .GRAVITY (GRAVITY),
        .FLOOR_Y (FLOOR_Y)
    ) u_alu (
        .clk    (sys_clk),
        .rst    (sys_rst),
        .i_load (w_load),
        .i_obj  (w_rd_obj),
        .i_dt   (r_dt),
        .o_obj  (w_alu_obj)
    );

    assign rd_addr = r_idx;
    assign wr_addr = r_idx;
    assign wr_data = w_alu_obj;

endmodule
`default_nettype wire

// File: tb/tb_phys_sweep_integrator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_phys_sweep_integrator
// Description : Scoreboard bench: expected RAM writes queued by the stimulus,
//               popped and compared by a monitor on every DUT write.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_phys_sweep_integrator;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [13:0] time_step = '0;
    logic [3:0]  obj_active = '0;
    logic        busy, done, rd_en, wr_en;
    logic [1:0]  rd_addr, wr_addr;
    logic [63:0] rd_data, wr_data;

    logic [63:0] mem [N];
    logic        pl_en = 1'b0;
    logic [1:0]  pl_addr = '0;
    logic [63:0] pl_data = '0;

    int n_cmp = 0;
    int n_err = 0;
    int n_done = 0;
    int exp_done = 0;
    int cyc;

    logic [1:0]  q_addr [$];
    logic [63:0] q_data [$];

    phys_sweep_integrator #(
        .NUM_OBJ (N),
        .GRAVITY (16),
        .FLOOR_Y (1000)
    ) dut (
        .sys_clk    (clk),
        .sys_rst    (rst),
        .start      (start),
        .time_step  (time_step),
        .obj_active (obj_active),
        .busy       (busy),
        .done       (done),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
    );

    always #5 clk = ~clk;

    // Object RAM with one-cycle read latency and a bench preload port.
    always @(posedge clk) begin
        if (pl_en)
            mem[pl_addr] <= pl_data;
        else if (wr_en)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

    function automatic logic [63:0] pk(input int px, input int py, input int vx, input int vy);
        return {px[15:0], py[15:0], vx[15:0], vy[15:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (done)
                n_done++;
            if (wr_en) begin
                check("rd_wr_overlap", 64'(rd_en), 64'd0);
                if (q_addr.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: got addr %0d data %h expected none", wr_addr, wr_data);
                end else begin
                    check("wr_addr", 64'(wr_addr), 64'(q_addr.pop_front()));
                    check("wr_data", wr_data, q_data.pop_front());
                end
            end
        end
    end

    task automatic push(input logic [1:0] a, input logic [63:0] d);
        q_addr.push_back(a);
        q_data.push_back(d);
    endtask

    task automatic preload(input logic [1:0] a, input logic [63:0] d);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    task automatic pulse_start(input logic [13:0] dt, input logic [3:0] act);
        @(negedge clk);
        time_step  = dt;
        obj_active = act;
        start      = 1'b1;
        @(posedge clk);
        cyc = 1;
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_cyc);
        while (!done && cyc < 200) begin
            @(posedge clk);
            #1 cyc++;
        end
        check(name, 64'(cyc), 64'(exp_cyc));
        check("busy_at_done", 64'(busy), 64'd0);
        exp_done++;
        @(posedge clk);
        #1;
    endtask

    task automatic sweep(input string name, input logic [13:0] dt, input logic [3:0] act, input int exp_cyc);
        pulse_start(dt, act);
        wait_done(name, exp_cyc);
    endtask

    initial begin
        preload(2'd0, pk(0, 0, 16, 0));
        preload(2'd1, pk(100, 200, -32, 48));
        preload(2'd2, pk(32760, 0, 100, 0));
        preload(2'd3, pk(-32760, 5, -100, -16));
        @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rd_en", 64'(rd_en), 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_data", wr_data, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // All slots, dt = 1.0; slots 2/3 saturate pos_x.
        push(2'd0, pk(16, 0, 16, 16));
        push(2'd1, pk(68, 248, -32, 64));
        push(2'd2, pk(32767, 0, 100, 16));
        push(2'd3, pk(-32768, -11, -100, 0));
        sweep("lat_all", 14'd4096, 4'b1111, 13);

        // Sparse activity: only slots 0 and 2.
        push(2'd0, pk(32, 16, 16, 32));
        push(2'd2, pk(32767, 16, 100, 32));
        sweep("lat_sparse", 14'd4096, 4'b0101, 9);
        check("slot1_kept", mem[1], pk(68, 248, -32, 64));
        check("slot3_kept", mem[3], pk(-32768, -11, -100, 0));

        // dt = 0 writes back unchanged.
        push(2'd1, pk(68, 248, -32, 64));
        sweep("lat_dt0", 14'd0, 4'b0010, 7);

        // dt = -1.0 (14'h3000) integrates backwards.
        push(2'd3, pk(-32668, -11, -100, -16));
        sweep("lat_neg", 14'h3000, 4'b1000, 7);

        // dt = 0.5
        push(2'd1, pk(52, 280, -32, 72));
        sweep("lat_half", 14'd2048, 4'b0010, 7);

        // Start while busy is ignored; dt and mask stay latched.
        push(2'd0, pk(48, 48, 16, 48));
        pulse_start(14'd4096, 4'b0001);
        @(posedge clk);
        #1 cyc++;
        start      = 1'b1;
        time_step  = 14'd0;
        obj_active = 4'b1111;
        @(posedge clk);
        #1 cyc++;
        start = 1'b0;
        wait_done("lat_restart", 7);
        repeat (10) @(posedge clk);
        #1;

        // Reset during slot 2 CALC: slots 0/1 written, nothing after.
        push(2'd0, pk(64, 96, 16, 64));
        push(2'd1, pk(20, 352, -32, 88));
        pulse_start(14'd4096, 4'b1111);
        repeat (7) @(posedge clk);
        #1;
        check("pre_rst_rd_addr", 64'(rd_addr), 64'd2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_wr_en", 64'(wr_en), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("slot2_untouched", mem[2], pk(32767, 16, 100, 32));
        check("slot3_untouched", mem[3], pk(-32668, -11, -100, -16));

`ifdef PHYS_FLOOR_BOUNCE_EN
        preload(2'd0, pk(0, 990, 0, 400));
        push(2'd0, pk(0, 1000, 0, -208));
        sweep("lat_floor", 14'd4096, 4'b0001, 7);
`endif

        @(posedge clk);
        #1;
        check("queue_drained", 64'(q_addr.size()), 64'd0);
        check("done_count", 64'(n_done), 64'(exp_done));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
